// File: rtl/fft32_ctrl_if.sv
// Handshake and control bundle between the FFT32 sequencer and its datapath/source.
interface fft32_ctrl_if;
    logic        in_valid;
    logic        en;
    logic [4:0]  phase;
    logic [19:0] tw_idx;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        frame_done;
    logic [1:0]  state;

    modport master (
        output in_valid,
        input  en, phase, tw_idx, out_valid, out_idx, frame_done, state
    );

    modport slave (
        input  in_valid,
        output en, phase, tw_idx, out_valid, out_idx, frame_done, state
    );
endinterface

// File: rtl/fft32_ctrl.sv
// Sequencer for a 32-point radix-2 DIF single-delay-feedback FFT (5 stages, D_k = 16>>k).
// Define FFT32_CTRL_BITREV_EN to report out_idx as the natural frequency bin.
module fft32_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    fft32_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Advance count at which each stage sees its first sample.
    localparam int unsigned OFF [5] = '{0, 17, 26, 31, 34};

    logic [4:0]      in_idx_q, in_idx_d;
    logic [35:0]     vshift_q, vshift_d;
    logic [4:1][4:0] c_q, c_d;
    logic [4:0]      out_cnt_q, out_cnt_d;

    logic [1:0] state_w;
    logic       en_w;
    logic       out_valid_w;

    // State is a same-cycle decode so that FLUSH advances start on the very
    // first idle cycle after a frame, leaving no bubble in the pipeline.
    always_comb begin
        state_w = ST_IDLE;
        if (!reset_n)
            state_w = ST_IDLE;
        else if (bus.in_valid)
            state_w = ST_RUN;
        else if (in_idx_q != '0)
            state_w = ST_HOLD;
        else if (vshift_q != '0)
            state_w = ST_FLUSH;
    end

    assign en_w        = reset_n & (bus.in_valid | (state_w == ST_FLUSH));
    assign out_valid_w = en_w & vshift_q[35];

    always_comb begin
        in_idx_d  = in_idx_q;
        vshift_d  = vshift_q;
        c_d       = c_q;
        out_cnt_d = out_cnt_q;
        if (en_w) begin
            vshift_d = {vshift_q[34:0], bus.in_valid};
            if (bus.in_valid)
                in_idx_d = in_idx_q + 5'd1;
            for (int unsigned k = 1; k < 5; k++) begin
                if (vshift_q[OFF[k] - 1])
                    c_d[k] = c_q[k] + 5'd1;
            end
        end
        if (out_valid_w)
            out_cnt_d = out_cnt_q + 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_idx_q  <= '0;
            vshift_q  <= '0;
            c_q       <= '0;
            out_cnt_q <= '0;
        end else begin
            in_idx_q  <= in_idx_d;
            vshift_q  <= vshift_d;
            c_q       <= c_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Stage 0 counts inputs directly; twiddle = (c_k mod D_k) << k in 4 bits.
    assign bus.phase  = {c_q[4][0], c_q[3][1], c_q[2][2], c_q[1][3], in_idx_q[4]};
    assign bus.tw_idx = {4'd0,
                         c_q[3][0],   3'b000,
                         c_q[2][1:0], 2'b00,
                         c_q[1][2:0], 1'b0,
                         in_idx_q[3:0]};

    assign bus.en         = en_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.frame_done = out_valid_w & (out_cnt_q == 5'd31);
    assign bus.state      = state_w;

`ifdef FFT32_CTRL_BITREV_EN
    assign bus.out_idx = {out_cnt_q[0], out_cnt_q[1], out_cnt_q[2], out_cnt_q[3], out_cnt_q[4]};
`else
    assign bus.out_idx = out_cnt_q;
`endif

endmodule

// File: tb/tb_fft32_ctrl.sv
// Directed bench for fft32_ctrl: reset, single frame, mid-frame gap, back-to-back,
// input during flush, and reset during flush, against hand-computed cycle counts.
module tb_fft32_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic clk = 1'b0;
    logic reset_n;

    fft32_ctrl_if bus_if ();

    fft32_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic        pat    [0:255];
    logic        rpat   [0:255];
    logic [1:0]  st_log [0:255];
    logic [4:0]  ph_log [0:255];
    logic [19:0] tw_log [0:255];
    logic        ov_log [0:255];

    int en_cnt, run_cnt, hold_cnt, flush_cnt, idle_cnt;
    int ov_cnt, first_ov_en, last_ov_en, first_ov_cyc, last_ov_cyc;
    int fd_cnt, fd1, fd2, idx_err, second_idx, hold_chg, tw4_nz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [4:0] exp_idx(input int n);
        logic [4:0] r;
        logic [4:0] o;
        r = n[4:0];
        o = r;
`ifdef FFT32_CTRL_BITREV_EN
        o = {r[0], r[1], r[2], r[3], r[4]};
`endif
        return o;
    endfunction

    task automatic clear_pat();
        for (int i = 0; i < 256; i++) begin
            pat[i]  = 1'b0;
            rpat[i] = 1'b1;
        end
    endtask

    task automatic set_valid(input int start, input int n);
        for (int i = start; i < start + n; i++)
            pat[i] = 1'b1;
    endtask

    task automatic run_pat(input int len);
        en_cnt = 0; run_cnt = 0; hold_cnt = 0; flush_cnt = 0; idle_cnt = 0;
        ov_cnt = 0; first_ov_en = -1; last_ov_en = -1; first_ov_cyc = -1; last_ov_cyc = -1;
        fd_cnt = 0; fd1 = -1; fd2 = -1; idx_err = 0; second_idx = -1; hold_chg = 0; tw4_nz = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            reset_n         = rpat[i];
            bus_if.in_valid = pat[i];
            #1;
            st_log[i] = bus_if.state;
            ph_log[i] = bus_if.phase;
            tw_log[i] = bus_if.tw_idx;
            ov_log[i] = bus_if.out_valid;
            if (bus_if.en) en_cnt++;
            case (bus_if.state)
                ST_IDLE:  idle_cnt++;
                ST_RUN:   run_cnt++;
                ST_HOLD:  hold_cnt++;
                default:  flush_cnt++;
            endcase
            if (i > 0 && bus_if.state == ST_HOLD && st_log[i-1] == ST_HOLD &&
                (ph_log[i] != ph_log[i-1] || tw_log[i] != tw_log[i-1]))
                hold_chg++;
            if (bus_if.tw_idx[19:16] != 4'd0) tw4_nz++;
            if (bus_if.out_valid) begin
                if (ov_cnt == 0) begin
                    first_ov_en  = en_cnt;
                    first_ov_cyc = i + 1;
                end
                last_ov_en  = en_cnt;
                last_ov_cyc = i + 1;
                if (ov_cnt == 1) second_idx = int'(bus_if.out_idx);
                if (bus_if.out_idx != exp_idx(ov_cnt)) idx_err++;
                ov_cnt++;
            end
            if (bus_if.frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd1 = en_cnt;
                else             fd2 = en_cnt;
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus_if.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_en",        int'(bus_if.en),         0);
        check("rst_out_valid", int'(bus_if.out_valid),  0);
        check("rst_state",     int'(bus_if.state),      int'(ST_IDLE));
        check("rst_tw_idx",    int'(bus_if.tw_idx),     0);
        check("rst_phase",     int'(bus_if.phase),      0);
        check("rst_frame_done",int'(bus_if.frame_done), 0);

        // Single frame: 32 inputs then idle.
        clear_pat();
        set_valid(0, 32);
        run_pat(80);
        check("sf_en_cnt",     en_cnt,      68);
        check("sf_run_cnt",    run_cnt,     32);
        check("sf_flush_cnt",  flush_cnt,   36);
        check("sf_hold_cnt",   hold_cnt,    0);
        check("sf_ov_cnt",     ov_cnt,      32);
        check("sf_first_ov",   first_ov_en, 37);
        check("sf_last_ov",    last_ov_en,  68);
        check("sf_fd_cnt",     fd_cnt,      1);
        check("sf_fd_at",      fd1,         68);
        check("sf_idx_err",    idx_err,     0);
        check("sf_final_state",int'(st_log[79]), int'(ST_IDLE));
`ifdef FFT32_CTRL_BITREV_EN
        check("sf_second_idx", second_idx,  16);
`else
        check("sf_second_idx", second_idx,  1);
`endif
        check("tw0_c13",       int'(tw_log[13][3:0]), 13);
        check("ph0_c13",       int'(ph_log[13][0]),   0);
        check("ph0_c20",       int'(ph_log[20][0]),   1);
        check("tw1_c3",        int'(tw_log[20][7:4]), 6);
        check("ph1_c3",        int'(ph_log[20][1]),   0);
        check("tw2_c3",        int'(tw_log[29][11:8]), 12);
        check("ph2_c3",        int'(ph_log[29][2]),   0);
        check("tw4_zero",      tw4_nz,      0);

        // Mid-frame gap: 10 inputs, 5 idle, 22 inputs.
        clear_pat();
        set_valid(0, 10);
        set_valid(15, 22);
        run_pat(90);
        check("gap_hold_cnt",  hold_cnt,     5);
        check("gap_hold_state",int'(st_log[12]), int'(ST_HOLD));
        check("gap_hold_chg",  hold_chg,     0);
        check("gap_en_cnt",    en_cnt,       68);
        check("gap_first_ov",  first_ov_cyc, 42);
        check("gap_last_ov",   last_ov_cyc,  73);
        check("gap_ov_cnt",    ov_cnt,       32);

        // Back-to-back: 64 contiguous inputs.
        clear_pat();
        set_valid(0, 64);
        run_pat(110);
        check("b2b_hold_cnt",  hold_cnt,     0);
        check("b2b_run_cnt",   run_cnt,      64);
        check("b2b_flush_cnt", flush_cnt,    36);
        check("b2b_ov_cnt",    ov_cnt,       64);
        check("b2b_ov_contig", last_ov_cyc - first_ov_cyc + 1, 64);
        check("b2b_first_ov",  first_ov_cyc, 37);
        check("b2b_fd_cnt",    fd_cnt,       2);
        check("b2b_fd_space",  fd2 - fd1,    32);
        check("b2b_idx_err",   idx_err,      0);

        // Next frame arrives 10 cycles into the previous frame's flush.
        clear_pat();
        set_valid(0, 32);
        set_valid(42, 32);
        run_pat(120);
        check("ovl_en_cnt",    en_cnt,       110);
        check("ovl_hold_cnt",  hold_cnt,     0);
        check("ovl_flush_cnt", flush_cnt,    46);
        check("ovl_ov_cnt",    ov_cnt,       64);
        check("ovl_fd1",       fd1,          68);
        check("ovl_fd2",       fd2,          110);
        check("ovl_idx_err",   idx_err,      0);

        // Reset pulse 10 cycles into flush, while outputs are streaming.
        clear_pat();
        set_valid(0, 32);
        rpat[42] = 1'b0;
        rpat[43] = 1'b0;
        run_pat(84);
        check("mfr_en_cnt",    en_cnt,       42);
        check("mfr_ov_cnt",    ov_cnt,       6);
        check("mfr_ov_at_rst", int'(ov_log[42]), 0);
        check("mfr_st_at_rst", int'(st_log[42]), int'(ST_IDLE));
        check("mfr_fd_cnt",    fd_cnt,       0);
        check("mfr_idle_cnt",  idle_cnt,     42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
